// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM encoding, timeout
// defaults and the address alignment helper used when a request is latched.
package dmem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int TMO_W           = 8;

  // Loads fetch the whole word; stores keep the byte address for the slave.
  function automatic logic [31:0] bus_addr(input logic wr, input logic [31:0] addr);
    return wr ? addr : {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_req_latch.sv
// Enable-register bank holding the bus request fields for one transaction.
module dmem_req_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        wr_d,
  input  logic [3:0]  wstrb_d,
  input  logic [31:0] addr_d,
  input  logic [31:0] wdata_d,
  output logic        wr,
  output logic [3:0]  wstrb,
  output logic [31:0] addr,
  output logic [31:0] wdata
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr    <= 1'b0;
      wstrb <= 4'b0000;
      addr  <= 32'd0;
      wdata <= 32'd0;
    end else if (load) begin
      wr    <= wr_d;
      wstrb <= wstrb_d;
      addr  <= addr_d;
      wdata <= wdata_d;
    end
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// MEM-stage to req/addr_ok/data_ok bus bridge with pipeline stall generation.
// Optional WAIT-state abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreq_i,
  input  logic        memwrite_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_ext_i,
  output logic        stall_mem_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: data_req stays high (fields frozen) until a cycle with
  // data_addr_ok=1; data_data_ok counts only in that same cycle or after it.

  state_t state_q, state_d;
  logic   tmo_hit;
  logic   resp_ok;
  logic   issue;

  assign issue     = (state_q == S_IDLE) && memreq_i;
  assign resp_ok   = ((state_q == S_REQ) && data_addr_ok && data_data_ok) ||
                     ((state_q == S_WAIT) && data_data_ok);
  assign dbg_state = state_q;

  dmem_req_latch u_req_latch (
    .clk     (clk),
    .rst     (rst),
    .load    (issue),
    .wr_d    (memwrite_i),
    .wstrb_d (memwrite_i ? wstrb_i : 4'b0000),
    .addr_d  (bus_addr(memwrite_i, addr_i)),
    .wdata_d (wdata_i),
    .wr      (data_wr),
    .wstrb   (data_wstrb),
    .addr    (data_addr),
    .wdata   (data_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (memreq_i) state_d = S_REQ;
      S_REQ:  if (data_addr_ok) state_d = data_data_ok ? S_DONE : S_WAIT;
      S_WAIT: if (data_data_ok || tmo_hit) state_d = S_DONE;
      S_DONE: if (!stall_ext_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_req    = 1'b0;
    stall_mem_o = 1'b0;
    unique case (state_q)
      S_IDLE: stall_mem_o = memreq_i;
      S_REQ: begin
        data_req    = 1'b1;
        stall_mem_o = 1'b1;
      end
      S_WAIT: stall_mem_o = 1'b1;
      S_DONE: stall_mem_o = 1'b0;
      default: stall_mem_o = 1'b0;
    endcase
  end

  // Read data only moves on a load completion or an abort, so it holds through DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      rdata_o <= 32'd0;
    else if (resp_ok && !data_wr)  rdata_o <= data_rdata;
    else if (tmo_hit)              rdata_o <= 32'd0;
  end

`ifdef DMEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (state_q == S_WAIT) && !data_data_ok &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    tmo_cnt <= '0;
    else if (state_q != S_WAIT)  tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   err_q <= 1'b0;
    else if (tmo_hit)                           err_q <= 1'b1;
    else if (state_q == S_DONE && !stall_ext_i) err_q <= 1'b0;
  end
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: a behavioural bus slave, a driver that
// queues hand-computed expectations, and a monitor that checks each completion.
module tb_dmem_bus_bridge;
  import dmem_bus_bridge_pkg::*;

  localparam int EW = 118;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreq, memwrite, stall_ext;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        stall_mem, err;
  logic [31:0] rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  // slave configuration, set by the driver before each access
  int   addr_lat = 0;
  int   data_lat = 0;
  logic spur     = 1'b0;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.TIMEOUT_CYC(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .memreq_i     (memreq),
    .memwrite_i   (memwrite),
    .wstrb_i      (wstrb),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_ext_i  (stall_ext),
    .stall_mem_o  (stall_mem),
    .rdata_o      (rdata),
    .err_o        (err),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .dbg_state    (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Bus slave: accepts after addr_lat REQ cycles, answers data_lat cycles later.
  int   s_rq = 0;
  int   s_since = 0;
  logic s_acc = 1'b0;
  always @(negedge clk) begin
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (data_req) begin
      s_acc = 1'b0;
      if (s_rq == addr_lat) begin
        data_addr_ok = 1'b1;
        s_rq = 0;
        if (data_lat == 0) data_data_ok = 1'b1;
        else begin
          s_acc = 1'b1;
          s_since = 0;
        end
      end else begin
        s_rq++;
        data_data_ok = spur;
      end
    end else if (s_acc) begin
      s_since++;
      if (s_since == data_lat) begin
        data_data_ok = 1'b1;
        s_acc = 1'b0;
      end
    end
  end

  // Monitor: counts stall/req cycles and checks each transaction on DONE entry.
  int          m_stall = 0;
  int          m_req = 0;
  logic [1:0]  m_prev = 2'd0;
  logic [31:0] snap_addr, snap_wdata, hold_rdata;
  logic [3:0]  snap_wstrb;
  logic        hold_err;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      m_stall = 0;
      m_req   = 0;
      m_prev  = S_IDLE;
    end else begin
      if (stall_mem) m_stall++;
      if (data_req) m_req++;
      if (dbg_state == S_REQ) begin
        if (m_prev == S_REQ) begin
          chk("req_addr_stable", data_addr, snap_addr);
          chk("req_wdata_stable", data_wdata, snap_wdata);
          chk("req_wstrb_stable", 32'(data_wstrb), 32'(snap_wstrb));
        end
        snap_addr  = data_addr;
        snap_wdata = data_wdata;
        snap_wstrb = data_wstrb;
      end
      if (dbg_state == S_DONE && m_prev != S_DONE) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got a completion expected none");
        end else begin
          e = exp_q.pop_front();
          chk("bus_addr", data_addr, e[117:86]);
          chk("bus_wstrb", 32'(data_wstrb), 32'(e[85:82]));
          chk("bus_wr", 32'(data_wr), 32'(e[81]));
          chk("bus_wdata", data_wdata, e[80:49]);
          chk("rdata", rdata, e[48:17]);
          chk("err", 32'(err), 32'(e[16]));
          chk("stall_cycles", 32'(m_stall), 32'(e[15:8]));
          chk("req_cycles", 32'(m_req), 32'(e[7:0]));
        end
        m_stall    = 0;
        m_req      = 0;
        hold_rdata = rdata;
        hold_err   = err;
      end else if (dbg_state == S_DONE) begin
        chk("done_no_req", 32'(data_req), 32'd0);
        chk("done_rdata_hold", rdata, hold_rdata);
        chk("done_err_hold", 32'(err), 32'(hold_err));
      end
      m_prev = dbg_state;
    end
  end

  // Issue one access starting in IDLE at posedge+1; returns at posedge+1 in IDLE.
  task automatic access(input logic wr, input logic [3:0] ws, input logic [31:0] a,
                        input logic [31:0] wd, input int al, input int dl,
                        input logic sp, input logic [31:0] rd, input int hold,
                        input logic [31:0] x_addr, input logic [3:0] x_wstrb,
                        input logic [31:0] x_rdata, input logic x_err,
                        input int x_stall, input int x_req);
    int n;
    addr_lat   = al;
    data_lat   = dl;
    spur       = sp;
    data_rdata = rd;
    exp_q.push_back({x_addr, x_wstrb, wr, wd, x_rdata, x_err, 8'(x_stall), 8'(x_req)});
    memreq   = 1'b1;
    memwrite = wr;
    wstrb    = ws;
    addr     = a;
    wdata    = wd;
    n = 0;
    @(negedge clk);
    while (dbg_state != S_DONE && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (dbg_state != S_DONE) begin
      n_checks++;
      $display("FAIL done_wait: got no DONE expected DONE within 300 cycles");
    end
    if (hold > 0) begin
      stall_ext = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("ext_stall_done", 32'(dbg_state), 32'(S_DONE));
        chk("ext_stall_no_stall", 32'(stall_mem), 32'd0);
      end
      stall_ext = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("back_to_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("idle_no_req", 32'(data_req), 32'd0);
    chk("idle_err_clear", 32'(err), 32'd0);
    memreq = 1'b0;
  endtask

  task automatic idle(input int n);
    memreq = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; memreq = 1'b0; memwrite = 1'b0; stall_ext = 1'b0;
    wstrb = 4'h0; addr = 32'd0; wdata = 32'd0; data_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    rst = 1'b1;
    idle(1);

    // load, accept and response in first REQ cycle: word-aligned, 2 stall cycles
    access(1'b0, 4'hF, 32'h0000_1006, 32'h5555_5555, 0, 0, 1'b0, 32'h1122_3344, 0,
           32'h0000_1004, 4'h0, 32'h1122_3344, 1'b0, 2, 1);
    // store, 3 refused REQ cycles (with stray data_ok), one WAIT cycle
    access(1'b1, 4'b0011, 32'h0000_2002, 32'hAABB_CCDD, 3, 1, 1'b1, 32'h9999_9999, 0,
           32'h0000_2002, 4'b0011, 32'h1122_3344, 1'b0, 6, 4);
    idle(2);
    // load held in DONE by an external stall for 3 cycles
    access(1'b0, 4'h0, 32'h0000_3000, 32'h0, 1, 2, 1'b0, 32'hDEAD_BEEF, 3,
           32'h0000_3000, 4'h0, 32'hDEAD_BEEF, 1'b0, 5, 2);
    // back-to-back store then load
    access(1'b1, 4'b1000, 32'h0000_4001, 32'h1234_5678, 0, 0, 1'b0, 32'hFFFF_0000, 0,
           32'h0000_4001, 4'b1000, 32'hDEAD_BEEF, 1'b0, 2, 1);
    access(1'b0, 4'hF, 32'h0000_4007, 32'h0, 0, 3, 1'b0, 32'hCAFE_F00D, 0,
           32'h0000_4004, 4'h0, 32'hCAFE_F00D, 1'b0, 5, 1);
    idle(1);
`ifdef DMEM_TIMEOUT_EN
    // no response: abort after 4 WAIT cycles, err held through DONE
    access(1'b0, 4'h0, 32'h0000_6000, 32'h0, 0, -1, 1'b0, 32'h7777_7777, 2,
           32'h0000_6000, 4'h0, 32'h0000_0000, 1'b1, 6, 1);
`else
    // long response: WAIT simply lasts 12 cycles, never an error
    access(1'b0, 4'h0, 32'h0000_6000, 32'h0, 0, 12, 1'b0, 32'h7777_7777, 2,
           32'h0000_6000, 4'h0, 32'h7777_7777, 1'b0, 14, 1);
`endif
    idle(1);

    // reset while waiting for data; the late response must be dropped
    addr_lat = 0; data_lat = 6; spur = 1'b0; data_rdata = 32'h0BAD_BEEF;
    memreq = 1'b1; memwrite = 1'b0; wstrb = 4'h0; addr = 32'h0000_5008;
    begin
      int n = 0;
      @(negedge clk);
      while (dbg_state != S_WAIT && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("reached_wait", 32'(dbg_state), 32'(S_WAIT));
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    memreq = 1'b0;
    #1;
    chk("rst_wait_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_wait_req", 32'(data_req), 32'd0);
    chk("rst_wait_rdata", rdata, 32'd0);
    chk("rst_wait_stall", 32'(stall_mem), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stale_ok_state", 32'(dbg_state), 32'(S_IDLE));
      chk("stale_ok_rdata", rdata, 32'd0);
    end
    @(posedge clk);
    #1;
    // recovery after the aborted transaction
    access(1'b0, 4'h0, 32'h0000_7003, 32'h0, 0, 0, 1'b0, 32'h55AA_55AA, 0,
           32'h0000_7000, 4'h0, 32'h55AA_55AA, 1'b0, 2, 1);
    idle(2);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
